rf_wb_arbiter: RTL and testbench

Shares the single RegFile write port between the pipeline writeback stage and an auxiliary multi-cycle unit (load/mul-div return path). The pipeline normally has priority. The aux requester has a bounded-wait starvation guard and a same-address ordering rule. Write-port outputs are registered and drive RegFile we/wa/wd directly. The block sits between writeback and RegFile.

---
 rtl/rf_wb_arbiter_if.sv | 39 +++
 rtl/rf_wb_arbiter.sv | 69 ++++++
 tb/tb_rf_wb_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_if.sv
// RegFile write-port bundle: pipeline and aux write requests in, registered RegFile write out.
interface rf_wb_arbiter_if #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int MAX_WAIT = 4
);
    localparam int WCW = $clog2(MAX_WAIT + 1);

    logic              pipe_valid;
    logic [AWIDTH-1:0] pipe_wa;
    logic [DWIDTH-1:0] pipe_wd;
    logic              pipe_stall;

    logic              aux_valid;
    logic [AWIDTH-1:0] aux_wa;
    logic [DWIDTH-1:0] aux_wd;
    logic              aux_ready;

    logic              rf_we;
    logic [AWIDTH-1:0] rf_wa;
    logic [DWIDTH-1:0] rf_wd;
    logic [WCW-1:0]    wait_cnt;

    // Requester / RegFile side.
    modport master (
        output pipe_valid, pipe_wa, pipe_wd,
        output aux_valid, aux_wa, aux_wd,
        input  pipe_stall, aux_ready,
        input  rf_we, rf_wa, rf_wd, wait_cnt
    );

    // Arbiter side.
    modport slave (
        input  pipe_valid, pipe_wa, pipe_wd,
        input  aux_valid, aux_wa, aux_wd,
        output pipe_stall, aux_ready,
        output rf_we, rf_wa, rf_wd, wait_cnt
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Purpose: arbitrates the single RegFile write port between pipeline writeback and the aux unit.
// Latency: 1 cycle from acceptance to registered rf_we/rf_wa/rf_wd.
// Backpressure: combinational pipe_stall / aux_ready; aux preempts after MAX_WAIT lost cycles.
module rf_wb_arbiter #(
    parameter int DWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    rf_wb_arbiter_if.slave  bus
);
    localparam int             WCW  = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

    logic              same_addr;
    logic              starved;
    logic              grant_aux;
    logic              grant_pipe;

    logic              we_q;
    logic [AWIDTH-1:0] wa_q;
    logic [DWIDTH-1:0] wd_q;
    logic [WCW-1:0]    wait_q;

    // Same-address conflict: the aux result is the older producer, so it must land first.
    assign same_addr  = bus.pipe_valid && bus.aux_valid &&
                        (bus.pipe_wa == bus.aux_wa) && (bus.aux_wa != '0);
    assign starved    = bus.aux_valid && (wait_q == WMAX);
    assign grant_aux  = same_addr || starved || (bus.aux_valid && !bus.pipe_valid);
    assign grant_pipe = bus.pipe_valid && !grant_aux;

    assign bus.aux_ready  = grant_aux;
    assign bus.pipe_stall = bus.pipe_valid && !grant_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q <= 1'b0;
            wa_q <= '0;
            wd_q <= '0;
        end else if (grant_aux) begin
            // Writes to x0 complete the handshake but never reach the RegFile.
            we_q <= (bus.aux_wa != '0);
            wa_q <= bus.aux_wa;
            wd_q <= bus.aux_wd;
        end else if (grant_pipe) begin
            we_q <= (bus.pipe_wa != '0);
            wa_q <= bus.pipe_wa;
            wd_q <= bus.pipe_wd;
        end else begin
            we_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (!bus.aux_valid || grant_aux) begin
            wait_q <= '0;
        end else if (wait_q != WMAX) begin
            wait_q <= wait_q + 1'b1;
        end
    end

    assign bus.rf_we    = we_q;
    assign bus.rf_wa    = wa_q;
    assign bus.rf_wd    = wd_q;
    assign bus.wait_cnt = wait_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: vector table, directed corner sequences, randomized traffic vs. reference model.
module tb_rf_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int MW = 4;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    rf_wb_arbiter_if #(.DWIDTH(DW), .AWIDTH(AW), .MAX_WAIT(MW)) bus ();

    rf_wb_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RegFile fed by the arbiter's write port.
    logic [DW-1:0] rf_mem [32];
    always @(posedge clk) begin
        if (bus.rf_we) rf_mem[bus.rf_wa] <= bus.rf_wd;
    end

    typedef struct {
        logic          pv;
        logic [AW-1:0] pwa;
        logic [DW-1:0] pwd;
        logic          av;
        logic [AW-1:0] awa;
        logic [DW-1:0] awd;
        logic          stall;
        logic          rdy;
        logic          we;
        logic          chk_a;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [2:0]    wc;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [AW-1:0] pwa, input logic [DW-1:0] pwd,
                         input logic av, input logic [AW-1:0] awa, input logic [DW-1:0] awd);
        bus.pipe_valid = pv;
        bus.pipe_wa    = pwa;
        bus.pipe_wd    = pwd;
        bus.aux_valid  = av;
        bus.aux_wa     = awa;
        bus.aux_wd     = awd;
    endtask

    // Reference model state
    int            m_wait;
    logic          m_we;
    logic          m_known;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;

    initial begin
        logic          pv, av, same, aux_win, pipe_win, pipe_hold, aux_hold;
        logic [AW-1:0] pwa, awa;
        logic [DW-1:0] pwd, awd;
        int            age;

        errors = 0;
        checks = 0;

        vecs[0]  = '{1, 3, 32'h33, 0, 0, 0,     0, 0, 1, 1, 3, 32'h33, 0};
        vecs[1]  = '{0, 0, 0,      0, 0, 0,     0, 0, 0, 1, 3, 32'h33, 0};
        vecs[2]  = '{1, 7, 32'hA,  1, 7, 32'hB, 1, 1, 1, 1, 7, 32'hB,  0};
        vecs[3]  = '{1, 7, 32'hA,  0, 0, 0,     0, 0, 1, 1, 7, 32'hA,  0};
        vecs[4]  = '{0, 0, 0,      1, 0, 32'hFF,0, 1, 0, 0, 0, 0,      0};
        vecs[5]  = '{1, 0, 32'h11, 1, 0, 32'h22,0, 0, 0, 0, 0, 0,      1};
        vecs[6]  = '{1, 5, 32'h5,  1, 0, 32'h22,0, 0, 1, 1, 5, 32'h5,  2};
        vecs[7]  = '{0, 0, 0,      0, 0, 0,     0, 0, 0, 1, 5, 32'h5,  0};
        vecs[8]  = '{0, 0, 0,      1, 9, 32'h99,0, 1, 1, 1, 9, 32'h99, 0};
        vecs[9]  = '{1, 4, 32'h44, 1, 6, 32'h66,0, 0, 1, 1, 4, 32'h44, 1};
        vecs[10] = '{1, 4, 32'h44, 1, 6, 32'h66,0, 0, 1, 1, 4, 32'h44, 2};
        vecs[11] = '{1, 4, 32'h44, 1, 6, 32'h66,0, 0, 1, 1, 4, 32'h44, 3};
        vecs[12] = '{1, 4, 32'h44, 1, 6, 32'h66,0, 0, 1, 1, 4, 32'h44, 4};
        vecs[13] = '{1, 4, 32'h44, 1, 6, 32'h66,1, 1, 1, 1, 6, 32'h66, 0};
        vecs[14] = '{1, 4, 32'h44, 0, 0, 0,     0, 0, 1, 1, 4, 32'h44, 0};
        vecs[15] = '{0, 0, 0,      0, 0, 0,     0, 0, 0, 1, 4, 32'h44, 0};

        // Reset state
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check("reset_we", bus.rf_we, 0);
        check("reset_wa", bus.rf_wa, 0);
        check("reset_wd", bus.rf_wd, 0);
        check("reset_wc", bus.wait_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].pv, vecs[i].pwa, vecs[i].pwd, vecs[i].av, vecs[i].awa, vecs[i].awd);
            #1;
            check($sformatf("vec%0d_stall", i), bus.pipe_stall, vecs[i].stall);
            check($sformatf("vec%0d_ready", i), bus.aux_ready, vecs[i].rdy);
            tick();
            check($sformatf("vec%0d_we", i), bus.rf_we, vecs[i].we);
            check($sformatf("vec%0d_wc", i), bus.wait_cnt, vecs[i].wc);
            if (vecs[i].chk_a) begin
                check($sformatf("vec%0d_wa", i), bus.rf_wa, vecs[i].wa);
                check($sformatf("vec%0d_wd", i), bus.rf_wd, vecs[i].wd);
            end
        end
        check("rf_r3", rf_mem[3], 32'h33);
        check("rf_r7_order", rf_mem[7], 32'hA);
        check("rf_r5", rf_mem[5], 32'h5);
        check("rf_r6", rf_mem[6], 32'h66);

        // Starvation: pipe holds r1, aux waits on r2 until the guard fires
        drive(1, 1, 32'h11, 1, 2, 32'h22);
        for (int k = 1; k <= MW; k++) begin
            #1;
            check("starve_ready_lo", bus.aux_ready, 0);
            check("starve_stall_lo", bus.pipe_stall, 0);
            tick();
            check("starve_wc", bus.wait_cnt, k);
            check("starve_pipe_wa", bus.rf_wa, 1);
        end
        #1;
        check("starve_ready_hi", bus.aux_ready, 1);
        check("starve_stall_hi", bus.pipe_stall, 1);
        tick();
        check("starve_aux_wa", bus.rf_wa, 2);
        check("starve_aux_wd", bus.rf_wd, 32'h22);
        check("starve_wc_clr", bus.wait_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();

        // Asynchronous reset in the middle of a write, with aux waiting
        drive(1, 10, 32'hAA, 1, 11, 32'hBB);
        tick();
        check("pre_rst_we", bus.rf_we, 1);
        check("pre_rst_wc", bus.wait_cnt, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_we", bus.rf_we, 0);
        check("arst_wa", bus.rf_wa, 0);
        check("arst_wd", bus.rf_wd, 0);
        check("arst_wc", bus.wait_cnt, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("post_rst_we", bus.rf_we, 0);
        check("post_rst_wc", bus.wait_cnt, 0);

        // Randomized traffic against the reference model
        m_wait    = 0;
        m_known   = 0;
        m_wa      = '0;
        m_wd      = '0;
        pipe_hold = 0;
        aux_hold  = 0;
        age       = 0;
        pv = 0; av = 0; pwa = '0; awa = '0; pwd = '0; awd = '0;
        for (int c = 0; c < 2000; c++) begin
            if (!aux_hold) begin
                av  = ($urandom % 3) != 0;
                awa = AW'($urandom % 8);
                awd = $urandom;
            end
            if (!pipe_hold) begin
                pv  = ($urandom % 4) != 0;
                pwa = AW'($urandom % 8);
                pwd = $urandom;
            end
            drive(pv, pwa, pwd, av, awa, awd);
            #1;
            same     = pv && av && (pwa == awa) && (awa != 0);
            aux_win  = av && (same || (m_wait == MW) || !pv);
            pipe_win = pv && !aux_win;
            check("rnd_ready", bus.aux_ready, aux_win);
            check("rnd_stall", bus.pipe_stall, pv && !pipe_win);
            if (aux_win) check("rnd_aux_bound", (age <= MW), 1);
            tick();
            if (aux_win) begin
                m_we = (awa != 0); m_wa = awa; m_wd = awd; m_known = (awa != 0);
            end else if (pipe_win) begin
                m_we = (pwa != 0); m_wa = pwa; m_wd = pwd; m_known = (pwa != 0);
            end else begin
                m_we = 0;
            end
            if (!av || aux_win) m_wait = 0;
            else if (m_wait < MW) m_wait = m_wait + 1;
            check("rnd_we", bus.rf_we, m_we);
            check("rnd_wc", bus.wait_cnt, m_wait);
            if (m_known) begin
                check("rnd_wa", bus.rf_wa, m_wa);
                check("rnd_wd", bus.rf_wd, m_wd);
            end
            aux_hold  = av && !aux_win;
            pipe_hold = pv && !pipe_win;
            age       = aux_hold ? age + 1 : 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
